// File: rtl/mmio_uart_fifo_ctrl_if.sv
// mmio_uart_fifo_ctrl_if
//   Bundles the CPU MMIO bus and the UART transmitter/receiver handshakes
//   used by mmio_uart_fifo_ctrl.
//   master : the core/UART side (drives the *_in signals, observes the *_out signals)
//   slave  : the FIFO controller
//   Signals:
//     addr_in, data_in, we_in, re_in : CPU MMIO address, store data and strobes
//     data_reg_out                   : CPU load data
//     uart_tx_data_out/valid_out, uart_tx_ready_in : TX drain handshake
//     uart_rx_data_in/valid_in, uart_rx_ready_out  : RX fill handshake
//     irq_out                        : level interrupt
interface mmio_uart_fifo_ctrl_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] addr_in;
  logic [DWIDTH-1:0] data_in;
  logic              we_in;
  logic              re_in;
  logic [DWIDTH-1:0] data_reg_out;
  logic [7:0]        uart_tx_data_out;
  logic              uart_tx_valid_out;
  logic              uart_tx_ready_in;
  logic [7:0]        uart_rx_data_in;
  logic              uart_rx_valid_in;
  logic              uart_rx_ready_out;
  logic              irq_out;

  modport master (
    output addr_in, data_in, we_in, re_in,
    output uart_tx_ready_in, uart_rx_data_in, uart_rx_valid_in,
    input  data_reg_out, uart_tx_data_out, uart_tx_valid_out,
    input  uart_rx_ready_out, irq_out
  );

  modport slave (
    input  addr_in, data_in, we_in, re_in,
    input  uart_tx_ready_in, uart_rx_data_in, uart_rx_valid_in,
    output data_reg_out, uart_tx_data_out, uart_tx_valid_out,
    output uart_rx_ready_out, irq_out
  );
endinterface

// File: rtl/mmio_uart_fifo_ctrl.sv
// mmio_uart_fifo_ctrl
//   Buffers CPU traffic to and from the UART. CPU stores to TX_DATA fill a TX
//   FIFO that drains into the UART transmitter; bytes from the UART receiver
//   fill an RX FIFO that the CPU pops by loading RX_DATA. A STATUS register
//   exposes fullness, counts and two sticky error flags (RX overflow, TX drop).
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     bus  : mmio_uart_fifo_ctrl_if.slave (CPU MMIO bus + UART handshakes)
//   Optional feature macro: MMIO_UART_FIFO_IRQ_EN
//     defined   -> IRQ_EN register at 0x80000020 and a registered irq_out
//     undefined -> IRQ_EN reads 0, writes ignored, irq_out tied to 0
module mmio_uart_fifo_ctrl #(
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  mmio_uart_fifo_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [AWIDTH-1:0] ADDR_STATUS  = AWIDTH'(32'h8000_0000);
  localparam logic [AWIDTH-1:0] ADDR_RX_DATA = AWIDTH'(32'h8000_0004);
  localparam logic [AWIDTH-1:0] ADDR_TX_DATA = AWIDTH'(32'h8000_0008);
  localparam logic [AWIDTH-1:0] ADDR_CLEAR   = AWIDTH'(32'h8000_001C);
  localparam logic [AWIDTH-1:0] ADDR_IRQ_EN  = AWIDTH'(32'h8000_0020);

  logic [7:0]    txMem_q [DEPTH];
  logic [7:0]    rxMem_q [DEPTH];
  logic [PW-1:0] txRd_q, txRd_d, txWr_q, txWr_d;
  logic [PW-1:0] rxRd_q, rxRd_d, rxWr_q, rxWr_d;
  logic [CW-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
  logic          txDrop_q, txDrop_d, rxOvf_q, rxOvf_d;

  logic hitStatus, hitRxData, hitTxData, hitClear, hitIrqEn;
  logic txFull, txEmpty, rxFull, rxEmpty;
  logic txPush, txPop, rxPush, rxPop, txDropSet, rxOvfSet, clearFlags;
  logic [31:0]       statusWord;
  logic [7:0]        rxHead;
  logic [DWIDTH-1:0] irqRead;
  logic              unusedDataBits;

  assign hitStatus = (bus.addr_in == ADDR_STATUS);
  assign hitRxData = (bus.addr_in == ADDR_RX_DATA);
  assign hitTxData = (bus.addr_in == ADDR_TX_DATA);
  assign hitClear  = (bus.addr_in == ADDR_CLEAR);
  assign hitIrqEn  = (bus.addr_in == ADDR_IRQ_EN);

  // Fullness is taken from the pre-edge counts, so a push into a full FIFO is
  // rejected even when a pop happens in the same cycle.
  assign txFull  = (txCount_q == CW'(DEPTH));
  assign txEmpty = (txCount_q == '0);
  assign rxFull  = (rxCount_q == CW'(DEPTH));
  assign rxEmpty = (rxCount_q == '0);

  assign txPush     = bus.we_in && hitTxData && !txFull;
  assign txDropSet  = bus.we_in && hitTxData && txFull;
  assign txPop      = !txEmpty && bus.uart_tx_ready_in;
  assign rxPush     = bus.uart_rx_valid_in && !rxFull;
  assign rxOvfSet   = bus.uart_rx_valid_in && rxFull;
  assign rxPop      = bus.re_in && hitRxData && !rxEmpty;
  assign clearFlags = bus.we_in && hitClear;

  // Only the low byte of a store is meaningful to this block.
  assign unusedDataBits = ^bus.data_in[DWIDTH-1:8];

  // Next-state for pointers, counts and sticky flags. Set events beat a
  // same-cycle clear so no error is silently lost.
  always_comb begin
    txRd_d    = txRd_q;
    txWr_d    = txWr_q;
    rxRd_d    = rxRd_q;
    rxWr_d    = rxWr_q;
    txCount_d = txCount_q + CW'(txPush) - CW'(txPop);
    rxCount_d = rxCount_q + CW'(rxPush) - CW'(rxPop);
    txDrop_d  = txDrop_q;
    rxOvf_d   = rxOvf_q;
    if (txPush) txWr_d = txWr_q + PW'(1);
    if (txPop)  txRd_d = txRd_q + PW'(1);
    if (rxPush) rxWr_d = rxWr_q + PW'(1);
    if (rxPop)  rxRd_d = rxRd_q + PW'(1);
    if (clearFlags) begin
      txDrop_d = 1'b0;
      rxOvf_d  = 1'b0;
    end
    if (txDropSet) txDrop_d = 1'b1;
    if (rxOvfSet)  rxOvf_d  = 1'b1;
  end

  // Control state register; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      txRd_q    <= '0;
      txWr_q    <= '0;
      rxRd_q    <= '0;
      rxWr_q    <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      txDrop_q  <= 1'b0;
      rxOvf_q   <= 1'b0;
    end else begin
      txRd_q    <= txRd_d;
      txWr_q    <= txWr_d;
      rxRd_q    <= rxRd_d;
      rxWr_q    <= rxWr_d;
      txCount_q <= txCount_d;
      rxCount_q <= rxCount_d;
      txDrop_q  <= txDrop_d;
      rxOvf_q   <= rxOvf_d;
    end
  end

  // FIFO storage needs no reset: empty FIFOs never expose their contents.
  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWr_q] <= bus.data_in[7:0];
    if (rxPush) rxMem_q[rxWr_q] <= bus.uart_rx_data_in;
  end

  assign bus.uart_tx_valid_out = !txEmpty;
  assign bus.uart_tx_data_out  = txEmpty ? 8'h00 : txMem_q[txRd_q];
  assign bus.uart_rx_ready_out = 1'b1;
  assign rxHead                = rxEmpty ? 8'h00 : rxMem_q[rxRd_q];

  assign statusWord = {8'h00, 8'(rxCount_q), 8'(txCount_q), 3'b000,
                       txDrop_q, rxOvf_q, txEmpty, !rxEmpty, !txFull};

`ifdef MMIO_UART_FIFO_IRQ_EN
  logic [1:0] irqEn_q, irqEn_d;
  logic       irq_q, irq_d;

  // irq is computed from next state so it rises together with the STATUS bit.
  always_comb begin
    irqEn_d = irqEn_q;
    if (bus.we_in && hitIrqEn) irqEn_d = bus.data_in[1:0];
    irq_d = (irqEn_d[0] && (rxCount_d != '0)) ||
            (irqEn_d[1] && (txCount_d == '0));
  end

  // Interrupt enable and registered interrupt level.
  always_ff @(posedge clk) begin
    if (rst) begin
      irqEn_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqEn_q <= irqEn_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.irq_out = irq_q;
  assign irqRead     = DWIDTH'(irqEn_q);
`else
  assign bus.irq_out = 1'b0;
  assign irqRead     = '0;
`endif

  // Combinational load data; unmapped and write-only addresses read 0.
  always_comb begin
    bus.data_reg_out = '0;
    if (hitStatus)      bus.data_reg_out = DWIDTH'(statusWord);
    else if (hitRxData) bus.data_reg_out = DWIDTH'(rxHead);
    else if (hitIrqEn)  bus.data_reg_out = irqRead;
  end
endmodule

// File: tb/tb_mmio_uart_fifo_ctrl.sv
// tb_mmio_uart_fifo_ctrl
//   Self-checking bench for mmio_uart_fifo_ctrl: a vector table for the basic
//   register and FIFO behaviour, hand-written sequences for overflow,
//   simultaneous push/pop, reset and interrupt cases, and a scoreboard of
//   expected transmitter bytes. Honours MMIO_UART_FIFO_IRQ_EN.
module tb_mmio_uart_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CLEAR  = 32'h8000_001C;
  localparam logic [31:0] A_IRQEN  = 32'h8000_0020;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        txReady;
    logic        rxValid;
    logic [7:0]  rxData;
    logic [31:0] expRead;
    logic        expTxValid;
    logic [7:0]  expTxData;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] txQ [$];
  logic [7:0] expByte;
  vec_t vecs [19];

  mmio_uart_fifo_ctrl_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mmio_uart_fifo_ctrl #(.DEPTH(DEPTH), .AWIDTH(32), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; TX stores are pushed to the scoreboard when
  // the FIFO (modelled by the queue depth) has room.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic re, input logic rdy,
                               input logic rxv, input logic [7:0] rxd);
    bus.addr_in          = addr;
    bus.data_in          = wdata;
    bus.we_in            = we;
    bus.re_in            = re;
    bus.uart_tx_ready_in = rdy;
    bus.uart_rx_valid_in = rxv;
    bus.uart_rx_data_in  = rxd;
    if (we && addr == A_TX && !rst && txQ.size() < DEPTH) txQ.push_back(wdata[7:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(addr, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput(name, bus.data_reg_out, exp);
    tick();
  endtask

  // Transmitter model: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.uart_tx_valid_out === 1'b1 && bus.uart_tx_ready_in === 1'b1) begin
      if (txQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL tx_unexpected actual=0x%02h required=no_byte", bus.uart_tx_data_out);
      end else begin
        expByte = txQ.pop_front();
        checkOutput("tx_byte", 32'(bus.uart_tx_data_out), 32'(expByte));
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    //          addr        wdata        we re rdy rxv rxd    expRead        txv txd
    vecs[0]  = '{A_STATUS,  32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0005, 0, 8'h00, "reset_status"};
    vecs[1]  = '{A_RX,      32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "rx_empty_read"};
    vecs[2]  = '{A_TX,      32'h0000_0041, 1, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "store_41"};
    vecs[3]  = '{A_TX,      32'h0000_0042, 1, 0, 0, 0, 8'h00, 32'h0000_0000, 1, 8'h41, "store_42"};
    vecs[4]  = '{A_TX,      32'hFFFF_FF43, 1, 0, 0, 0, 8'h00, 32'h0000_0000, 1, 8'h41, "store_43"};
    vecs[5]  = '{A_STATUS,  32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0301, 1, 8'h41, "tx_count3_hold"};
    vecs[6]  = '{A_STATUS,  32'h0,       0, 1, 1, 0, 8'h00, 32'h0000_0301, 1, 8'h41, "tx_drain3"};
    vecs[7]  = '{A_STATUS,  32'h0,       0, 1, 1, 0, 8'h00, 32'h0000_0201, 1, 8'h42, "tx_drain2"};
    vecs[8]  = '{A_STATUS,  32'h0,       0, 1, 1, 0, 8'h00, 32'h0000_0101, 1, 8'h43, "tx_drain1"};
    vecs[9]  = '{A_STATUS,  32'h0,       0, 1, 1, 0, 8'h00, 32'h0000_0005, 0, 8'h00, "tx_drain0"};
    vecs[10] = '{A_STATUS,  32'h0,       0, 1, 0, 1, 8'hA5, 32'h0000_0005, 0, 8'h00, "rx_push_a5"};
    vecs[11] = '{A_STATUS,  32'h0,       0, 1, 0, 0, 8'h00, 32'h0001_0007, 0, 8'h00, "rx_count1"};
    vecs[12] = '{A_RX,      32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_00A5, 0, 8'h00, "rx_pop_a5"};
    vecs[13] = '{A_STATUS,  32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0005, 0, 8'h00, "rx_empty_again"};
    vecs[14] = '{32'h8000_0010, 32'h0,   0, 1, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "unmapped_read"};
    vecs[15] = '{32'h8000_000C, 32'hFF,  1, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "unmapped_write"};
    vecs[16] = '{A_STATUS,  32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0005, 0, 8'h00, "status_after_unmapped"};
    vecs[17] = '{32'h0000_0000, 32'h0,   0, 1, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "addr_zero_read"};
    vecs[18] = '{A_TX,      32'h0,       0, 1, 0, 0, 8'h00, 32'h0000_0000, 0, 8'h00, "tx_data_read"};

    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_irq", 32'(bus.irq_out), 32'h0);
    checkOutput("reset_rx_ready", 32'(bus.uart_rx_ready_out), 32'h1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re,
                    vecs[i].txReady, vecs[i].rxValid, vecs[i].rxData);
      @(negedge clk);
      checkOutput({vecs[i].name, "_rd"}, bus.data_reg_out, vecs[i].expRead);
      checkOutput({vecs[i].name, "_txv"}, 32'(bus.uart_tx_valid_out), 32'(vecs[i].expTxValid));
      checkOutput({vecs[i].name, "_txd"}, 32'(bus.uart_tx_data_out), 32'(vecs[i].expTxData));
      tick();
    end

    // TX overflow: nine stores with the transmitter stalled.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(A_TX, 32'h60 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
    end
    applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("tx_full_status", bus.data_reg_out, 32'h0000_0810);
    checkOutput("tx_full_head", 32'(bus.uart_tx_data_out), 32'h60);
    tick();
    applyStimulus(A_CLEAR, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    readCheck(A_STATUS, 32'h0000_0800, "tx_drop_cleared");
    // Store into full FIFO while the transmitter takes a byte.
    applyStimulus(A_TX, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    readCheck(A_STATUS, 32'h0000_0711, "tx_full_store_and_pop");
    applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.uart_tx_valid_out) break;
      tick();
    end
    checkOutput("tx_drain_done", 32'(bus.uart_tx_valid_out), 32'h0);
    checkOutput("tx_sb_empty", 32'(txQ.size()), 32'h0);
    tick();
    applyStimulus(A_CLEAR, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    // RX overflow: nine bytes with no CPU reads.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
      tick();
    end
    readCheck(A_STATUS, 32'h0008_000F, "rx_full_status");
    for (int i = 0; i < 8; i++) readCheck(A_RX, 32'h10 + 32'(i), "rx_drain_byte");
    readCheck(A_RX, 32'h0, "rx_drained_read");
    readCheck(A_STATUS, 32'h0000_000D, "rx_ovf_sticky");
    applyStimulus(A_CLEAR, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    readCheck(A_STATUS, 32'h0000_0005, "rx_ovf_cleared");

    // RX at count 3: simultaneous UART push and CPU pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21 + 8'(i));
      tick();
    end
    applyStimulus(A_RX, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h24);
    @(negedge clk);
    checkOutput("rx_pushpop_head", bus.data_reg_out, 32'h21);
    tick();
    readCheck(A_STATUS, 32'h0003_0007, "rx_pushpop_count");
    readCheck(A_RX, 32'h22, "rx_pushpop_next");
    readCheck(A_RX, 32'h23, "rx_pushpop_b3");
    readCheck(A_RX, 32'h24, "rx_pushpop_b4");

    // Reset mid-stream with bytes buffered in both FIFOs.
`ifdef MMIO_UART_FIFO_IRQ_EN
    applyStimulus(A_IRQEN, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    @(negedge clk);
    checkOutput("irq_tx_empty", 32'(bus.irq_out), 32'h1);
    tick();
`endif
    applyStimulus(A_TX, 32'h71, 1'b1, 1'b0, 1'b0, 1'b1, 8'h31);
    tick();
    applyStimulus(A_TX, 32'h72, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32);
    tick();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    txQ.delete();
    tick();
    rst = 1'b0;
    applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("midreset_status", bus.data_reg_out, 32'h0000_0005);
    checkOutput("midreset_txv", 32'(bus.uart_tx_valid_out), 32'h0);
    checkOutput("midreset_irq", 32'(bus.irq_out), 32'h0);
    checkOutput("midreset_rx_ready", 32'(bus.uart_rx_ready_out), 32'h1);
    tick();
    readCheck(A_IRQEN, 32'h0, "midreset_irq_en");

    // Interrupt on RX non-empty.
`ifdef MMIO_UART_FIFO_IRQ_EN
    applyStimulus(A_IRQEN, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(A_IRQEN, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    @(negedge clk);
    checkOutput("irq_en_read", bus.data_reg_out, 32'h1);
    checkOutput("irq_idle", 32'(bus.irq_out), 32'h0);
    tick();
    applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("irq_rx_status", bus.data_reg_out, 32'h0001_0007);
    checkOutput("irq_rx_high", 32'(bus.irq_out), 32'h1);
    tick();
    readCheck(A_RX, 32'h99, "irq_rx_pop");
    @(negedge clk);
    checkOutput("irq_rx_low", 32'(bus.irq_out), 32'h0);
    tick();
`else
    applyStimulus(A_IRQEN, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(A_IRQEN, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    @(negedge clk);
    checkOutput("irq_en_absent", bus.data_reg_out, 32'h0);
    tick();
    applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("noirq_rx_status", bus.data_reg_out, 32'h0001_0007);
    checkOutput("noirq_level", 32'(bus.irq_out), 32'h0);
    tick();
    readCheck(A_RX, 32'h99, "noirq_rx_pop");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_fifo_ctrl.md
Name: mmio_uart_fifo_ctrl

Overview:
Buffers CPU traffic to and from the UART so software no longer has to poll per byte. CPU-side MMIO loads and stores hit a TX FIFO, an RX FIFO and a status/control register file. The block drains the TX FIFO into the UART transmitter and fills the RX FIFO from the UART receiver, each over a ready/valid handshake. It sits between the core's memory-stage MMIO decode and the uart_transmitter/uart_receiver pair.

Parameters:
DEPTH, 8, entries per FIFO; power of 2, minimum 2
AWIDTH, 32, address width
DWIDTH, 32, data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
addr_in  in  AWIDTH  CPU MMIO address
data_in  in  DWIDTH  CPU store data
we_in  in  1  CPU store strobe, qualified by addr_in
re_in  in  1  CPU load strobe, qualified by addr_in
data_reg_out  out  DWIDTH  CPU load data, combinational from current state
uart_tx_data_out  out  8  byte to transmitter
uart_tx_valid_out  out  1  TX FIFO non-empty
uart_tx_ready_in  in  1  transmitter accepts byte
uart_rx_data_in  in  8  byte from receiver
uart_rx_valid_in  in  1  receiver has byte
uart_rx_ready_out  out  1  constant 1; receiver never stalls
irq_out  out  1  level interrupt; see Optional Feature

Behaviour:
- Reset (synchronous, rst high at posedge):
  - Both FIFOs empty, pointers and counts 0.
  - Sticky flags 0 and irq enable bits 0.
  - Outputs after reset: uart_tx_valid_out=0, irq_out=0, uart_rx_ready_out=1.
  - Reset mid-transfer discards all buffered bytes; no partial state survives.
- Each FIFO has rd_ptr and wr_ptr of width log2(DEPTH), wrapping modulo DEPTH, plus a count of width log2(DEPTH)+1. full = count==DEPTH; empty = count==0.
- Address map (exact match on full addr_in):
  - 0x80000000 STATUS, read-only:
    - bit0 = TX not full
    - bit1 = RX not empty
    - bit2 = TX empty
    - bit3 = RX overflow (sticky)
    - bit4 = TX drop (sticky)
    - [15:8] = TX count
    - [23:16] = RX count
    - all other bits 0
  - 0x80000004 RX_DATA, read:
    - data_reg_out = {zeros, RX head} when RX is non-empty, else 0.
    - Pop at posedge if re_in && !empty.
  - 0x80000008 TX_DATA, write:
    - Push data_in[7:0] at posedge if we_in && !full.
    - If full, the byte is discarded and TX drop is set.
  - 0x8000001C CLEAR, write: we_in clears both sticky flags. A set event in the same cycle wins over the clear.
  - 0x80000020 IRQ_EN, read/write:
    - bit0 = rx-nonempty irq enable
    - bit1 = tx-empty irq enable
  - Unmapped addresses read 0; writes to them are ignored.
- TX drain:
  - uart_tx_valid_out = !tx_empty; uart_tx_data_out = TX head (0 when empty).
  - Pop on posedge when valid && ready.
  - Data and valid must hold until the handshake completes.
- RX fill:
  - Push uart_rx_data_in on posedge when uart_rx_valid_in && !rx_full.
  - If valid while full, the byte is dropped and RX overflow is set. FIFO contents are unchanged.
- Simultaneous events:
  - Fullness is evaluated on the pre-edge state: push into a full FIFO is rejected even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves count unchanged and advances both pointers.
  - A CPU push and a UART pop of the TX FIFO in the same cycle are both honoured; likewise a UART push and a CPU pop of the RX FIFO.
- Latency:
  - CPU store to uart_tx_valid_out: 1 cycle.
  - RX byte to visibility in STATUS/RX_DATA: 1 cycle.
  - Loads are combinational; side effects (pops) occur at the edge.

Optional Feature:
MMIO_UART_FIFO_IRQ_EN
- Defined: irq_out is registered and equals (IRQ_EN[0] && rx_not_empty) || (IRQ_EN[1] && tx_empty), computed from next state, so it asserts the same cycle the STATUS bit becomes visible.
- Undefined:
  - irq_out is tied to 0.
  - The IRQ_EN register is not implemented; it reads 0 and writes are ignored.
  - STATUS, FIFO and handshake behaviour are unchanged.

Test Plan:
- Reset, then read 0x80000000 -> 0x00000005 (TX not full, TX empty); uart_tx_valid_out=0.
- uart_tx_ready_in=0; store 0x41,0x42,0x43 to 0x80000008; then raise ready -> transmitter receives 0x41,0x42,0x43 in order, one per ready cycle; STATUS TX count goes 3,2,1,0.
- uart_tx_ready_in=0; store DEPTH+1 bytes (9) -> STATUS bit0=0, bit4=1, TX count=8; the 9th byte is never sent; a store to 0x8000001C clears bit4.
- Drive 9 RX bytes 0x10..0x18 with no CPU reads -> bit3=1, RX count=8; loads from 0x80000004 return 0x10..0x17, then 0 once empty.
- Full TX FIFO, same cycle: uart_tx_ready_in=1 and CPU store 0x55 -> store rejected, TX drop set, count 8->7; RX FIFO at count 3 with a simultaneous push and CPU pop -> count stays 3 and the head advances.
- With MMIO_UART_FIFO_IRQ_EN defined: write IRQ_EN=0x1, inject one RX byte -> irq_out=1 next cycle; pop it -> irq_out=0. Assert rst mid-stream -> all counts 0, irq_out=0, IRQ_EN=0.
